// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding and load-use hazard detection (16-bit WISC).
// Define ID_EX_FORWARDING_EN for forwarding; otherwise any pending writer stalls the consumer.
module id_ex_operand_stage #(
   parameter int DATA_W = 16,
   parameter int REG_W  = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic              id_use_imm,
   input  logic [3:0]        id_oper,
   input  logic              id_invA,
   input  logic              id_invB,
   input  logic              id_cin,
   input  logic              id_sign,
   input  logic              id_wr_en,
   input  logic [REG_W-1:0]  id_wr_reg,
   input  logic              id_mem_rd,
   input  logic              exmem_valid,
   input  logic              exmem_wr_en,
   input  logic [REG_W-1:0]  exmem_wr_reg,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_valid,
   input  logic              memwb_wr_en,
   input  logic [REG_W-1:0]  memwb_wr_reg,
   input  logic [DATA_W-1:0] memwb_result,
   input  logic              flush,
   input  logic              ext_stall,
   output logic              ex_valid,
   output logic [3:0]        ex_oper,
   output logic              ex_invA,
   output logic              ex_invB,
   output logic              ex_cin,
   output logic              ex_sign,
   output logic [DATA_W-1:0] ex_inA,
   output logic [DATA_W-1:0] ex_inB,
   output logic              ex_wr_en,
   output logic [REG_W-1:0]  ex_wr_reg,
   output logic              ex_mem_rd,
   output logic              id_stall,
   output logic [15:0]       bubble_cnt
);

   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic              rs_used;
      logic              rt_used;
      logic [DATA_W-1:0] rs_data;
      logic [DATA_W-1:0] rt_data;
      logic [DATA_W-1:0] imm;
      logic              use_imm;
      logic [3:0]        oper;
      logic              inva;
      logic              invb;
      logic              cin;
      logic              sign;
      logic              wr_en;
      logic [REG_W-1:0]  wr_reg;
      logic              mem_rd;
   } bundle_t;

   bundle_t     bundle_q, bundle_d;
   logic [15:0] bubble_cnt_q, bubble_cnt_d;
   logic        lu;
   logic [DATA_W-1:0] rs_val, rt_val;

`ifdef ID_EX_FORWARDING_EN
   logic ex_load;
   assign ex_load = bundle_q.valid & bundle_q.mem_rd & bundle_q.wr_en & id_valid;
   assign lu = ex_load & ((id_rs_used & (id_rs == bundle_q.wr_reg)) |
                          (id_rt_used & (id_rt == bundle_q.wr_reg)));

   // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
   always_comb begin
      rs_val = bundle_q.rs_data;
      rt_val = bundle_q.rt_data;
      if (bundle_q.rs_used) begin
         if (exmem_valid && exmem_wr_en && exmem_wr_reg == bundle_q.rs)
            rs_val = exmem_result;
         else if (memwb_valid && memwb_wr_en && memwb_wr_reg == bundle_q.rs)
            rs_val = memwb_result;
      end
      if (bundle_q.rt_used) begin
         if (exmem_valid && exmem_wr_en && exmem_wr_reg == bundle_q.rt)
            rt_val = exmem_result;
         else if (memwb_valid && memwb_wr_en && memwb_wr_reg == bundle_q.rt)
            rt_val = memwb_result;
      end
   end
`else
   logic ex_wr, exmem_wr, rs_hit, rt_hit;
   logic unused_fwd;
   assign ex_wr    = bundle_q.valid & bundle_q.wr_en;
   assign exmem_wr = exmem_valid & exmem_wr_en;
   assign rs_hit   = id_rs_used & ((ex_wr & (id_rs == bundle_q.wr_reg)) |
                                   (exmem_wr & (id_rs == exmem_wr_reg)));
   assign rt_hit   = id_rt_used & ((ex_wr & (id_rt == bundle_q.wr_reg)) |
                                   (exmem_wr & (id_rt == exmem_wr_reg)));
   assign lu       = id_valid & (rs_hit | rt_hit);
   assign rs_val   = bundle_q.rs_data;
   assign rt_val   = bundle_q.rt_data;
   assign unused_fwd = ^{exmem_result, memwb_valid, memwb_wr_en, memwb_wr_reg, memwb_result,
                         bundle_q.rs, bundle_q.rt, bundle_q.rs_used, bundle_q.rt_used};
`endif

   assign id_stall = lu | ext_stall;

   always_comb begin
      bundle_d     = bundle_q;
      bubble_cnt_d = bubble_cnt_q;
      if (ext_stall) begin
         bundle_d = bundle_q;
      end else if (flush) begin
         bundle_d.valid = 1'b0;
      end else if (lu) begin
         bundle_d.valid = 1'b0;
         if (bubble_cnt_q != 16'hFFFF) bubble_cnt_d = bubble_cnt_q + 16'd1;
      end else begin
         bundle_d = '{valid: id_valid, rs: id_rs, rt: id_rt, rs_used: id_rs_used,
                      rt_used: id_rt_used, rs_data: id_rs_data, rt_data: id_rt_data,
                      imm: id_imm, use_imm: id_use_imm, oper: id_oper, inva: id_invA,
                      invb: id_invB, cin: id_cin, sign: id_sign, wr_en: id_wr_en,
                      wr_reg: id_wr_reg, mem_rd: id_mem_rd};
      end
   end

   // NOTE: reset clears every stored field, not only valid, so operands read 0 after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bundle_q     <= '0;
         bubble_cnt_q <= '0;
      end else begin
         bundle_q     <= bundle_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign ex_valid   = bundle_q.valid;
   assign ex_oper    = bundle_q.oper;
   assign ex_invA    = bundle_q.inva;
   assign ex_invB    = bundle_q.invb;
   assign ex_cin     = bundle_q.cin;
   assign ex_sign    = bundle_q.sign;
   assign ex_inA     = rs_val;
   assign ex_inB     = bundle_q.use_imm ? bundle_q.imm : rt_val;
   assign ex_wr_en   = bundle_q.wr_en;
   assign ex_wr_reg  = bundle_q.wr_reg;
   assign ex_mem_rd  = bundle_q.mem_rd;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage; expectations adapt to ID_EX_FORWARDING_EN.
module tb_id_ex_operand_stage;

`ifdef ID_EX_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk, rst;
   logic        id_valid, id_rs_used, id_rt_used, id_use_imm;
   logic [2:0]  id_rs, id_rt, id_wr_reg;
   logic [15:0] id_rs_data, id_rt_data, id_imm;
   logic [3:0]  id_oper;
   logic        id_invA, id_invB, id_cin, id_sign, id_wr_en, id_mem_rd;
   logic        exmem_valid, exmem_wr_en, memwb_valid, memwb_wr_en;
   logic [2:0]  exmem_wr_reg, memwb_wr_reg;
   logic [15:0] exmem_result, memwb_result;
   logic        flush, ext_stall;
   logic        ex_valid, ex_invA, ex_invB, ex_cin, ex_sign, ex_wr_en, ex_mem_rd, id_stall;
   logic [3:0]  ex_oper;
   logic [15:0] ex_inA, ex_inB, bubble_cnt;
   logic [2:0]  ex_wr_reg;

   int checks = 0;
   int errors = 0;

   id_ex_operand_stage dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_imm(id_imm), .id_use_imm(id_use_imm), .id_oper(id_oper),
      .id_invA(id_invA), .id_invB(id_invB), .id_cin(id_cin), .id_sign(id_sign),
      .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg), .id_mem_rd(id_mem_rd),
      .exmem_valid(exmem_valid), .exmem_wr_en(exmem_wr_en),
      .exmem_wr_reg(exmem_wr_reg), .exmem_result(exmem_result),
      .memwb_valid(memwb_valid), .memwb_wr_en(memwb_wr_en),
      .memwb_wr_reg(memwb_wr_reg), .memwb_result(memwb_result),
      .flush(flush), .ext_stall(ext_stall),
      .ex_valid(ex_valid), .ex_oper(ex_oper), .ex_invA(ex_invA), .ex_invB(ex_invB),
      .ex_cin(ex_cin), .ex_sign(ex_sign), .ex_inA(ex_inA), .ex_inB(ex_inB),
      .ex_wr_en(ex_wr_en), .ex_wr_reg(ex_wr_reg), .ex_mem_rd(ex_mem_rd),
      .id_stall(id_stall), .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [2:0]  rs, rt;
      logic        used;
      logic [15:0] rs_d, rt_d, imm;
      logic        use_imm;
      logic [3:0]  oper;
      logic        flush, stall;
      logic        exp_stall, exp_valid, chk_data;
      logic [15:0] exp_a, exp_b;
      logic [3:0]  exp_oper;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                         input logic ru, input logic rtu, input logic [15:0] rsd,
                         input logic [15:0] rtd, input logic [15:0] imm, input logic ui,
                         input logic [3:0] op, input logic [2:0] wr, input logic mr);
      id_valid = v;      id_rs = rs;          id_rt = rt;
      id_rs_used = ru;   id_rt_used = rtu;    id_rs_data = rsd;
      id_rt_data = rtd;  id_imm = imm;        id_use_imm = ui;
      id_oper = op;      id_wr_en = 1'b1;     id_wr_reg = wr;
      id_mem_rd = mr;
   endtask

   task automatic set_fwd(input logic xv, input logic [2:0] xr, input logic [15:0] xd,
                          input logic mv, input logic [2:0] mr, input logic [15:0] md);
      exmem_valid = xv; exmem_wr_en = xv; exmem_wr_reg = xr; exmem_result = xd;
      memwb_valid = mv; memwb_wr_en = mv; memwb_wr_reg = mr; memwb_result = md;
   endtask

   initial begin
      // valid rs rt used rs_d rt_d imm use_imm oper flush stall | stall valid chk a b oper
      vecs[0] = '{1, 1, 2, 1, 16'h0011, 16'h0022, 16'h0000, 0, 4'h4, 0, 0, 0, 1, 1, 16'h0011, 16'h0022, 4'h4};
      vecs[1] = '{1, 3, 4, 1, 16'h1000, 16'h2000, 16'hFFF0, 1, 4'h2, 0, 0, 0, 1, 1, 16'h1000, 16'hFFF0, 4'h2};
      vecs[2] = '{1, 5, 6, 1, 16'h5555, 16'h6666, 16'h0000, 0, 4'h9, 1, 1, 1, 1, 1, 16'h1000, 16'hFFF0, 4'h2};
      vecs[3] = '{1, 5, 6, 1, 16'h5555, 16'h6666, 16'h0000, 0, 4'h9, 1, 1, 1, 1, 1, 16'h1000, 16'hFFF0, 4'h2};
      vecs[4] = '{1, 5, 6, 1, 16'h5555, 16'h6666, 16'h0000, 0, 4'h9, 1, 1, 1, 1, 1, 16'h1000, 16'hFFF0, 4'h2};
      vecs[5] = '{1, 5, 6, 1, 16'h5555, 16'h6666, 16'h0000, 0, 4'h9, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 4'h0};
      vecs[6] = '{0, 1, 2, 0, 16'h0AAA, 16'h0BBB, 16'h0000, 0, 4'h1, 0, 0, 0, 0, 1, 16'h0AAA, 16'h0BBB, 4'h1};
      vecs[7] = '{1, 5, 6, 1, 16'hABCD, 16'h1234, 16'h0000, 0, 4'hF, 0, 0, 0, 1, 1, 16'hABCD, 16'h1234, 4'hF};

      id_invA = 0; id_invB = 0; id_cin = 0; id_sign = 0;
      set_id(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 4'h0, 3'd7, 0);
      set_fwd(0, 0, 16'h0, 0, 0, 16'h0);
      flush = 0; ext_stall = 0;
      rst = 1;
      #12;
      check("reset_valid", 16'(ex_valid), 16'h0);
      check("reset_inA", ex_inA, 16'h0);
      check("reset_inB", ex_inB, 16'h0);
      check("reset_cnt", bubble_cnt, 16'h0);
      check("reset_stall", 16'(id_stall), 16'h0);
      rst = 0;
      step();

      // Table: hazard-free pipelining, immediate select, stall/flush priority
      for (int i = 0; i < 8; i++) begin
         set_id(vecs[i].valid, vecs[i].rs, vecs[i].rt, vecs[i].used, vecs[i].used,
                vecs[i].rs_d, vecs[i].rt_d, vecs[i].imm, vecs[i].use_imm, vecs[i].oper, 3'd7, 0);
         flush = vecs[i].flush;
         ext_stall = vecs[i].stall;
         #1;
         check($sformatf("v%0d_stall", i), 16'(id_stall), 16'(vecs[i].exp_stall));
         step();
         check($sformatf("v%0d_valid", i), 16'(ex_valid), 16'(vecs[i].exp_valid));
         check($sformatf("v%0d_cnt", i), bubble_cnt, 16'h0);
         if (vecs[i].chk_data) begin
            check($sformatf("v%0d_inA", i), ex_inA, vecs[i].exp_a);
            check($sformatf("v%0d_inB", i), ex_inB, vecs[i].exp_b);
            check($sformatf("v%0d_oper", i), 16'(ex_oper), 16'(vecs[i].exp_oper));
         end
      end
      flush = 0; ext_stall = 0;

      // Load-use coinciding with flush: flush wins, nothing counted
      set_id(1, 1, 0, 1, 0, 16'h0100, 16'h0, 16'h0, 0, 4'h0, 3'd4, 1);
      step();
      set_id(1, 4, 1, 1, 1, 16'h0000, 16'h0001, 16'h0, 0, 4'h4, 3'd5, 0);
      flush = 1;
      #1;
      check("lu_flush_stall", 16'(id_stall), 16'h1);
      step();
      flush = 0;
      check("lu_flush_valid", 16'(ex_valid), 16'h0);
      check("lu_flush_cnt", bubble_cnt, 16'h0);

      // Load-use: LD R4 then consumer of R4
      set_id(1, 1, 0, 1, 0, 16'h0100, 16'h0, 16'h0, 0, 4'h0, 3'd4, 1);
      #1;
      check("ld_enter_stall", 16'(id_stall), 16'h0);
      step();
      set_id(1, 4, 1, 1, 1, FWD ? 16'h0000 : 16'h00A5, 16'h0001, 16'h0, 0, 4'h4, 3'd5, 0);
      #1;
      check("lu_stall", 16'(id_stall), 16'h1);
      step();
      check("lu_bubble_valid", 16'(ex_valid), 16'h0);
      check("lu_bubble_cnt", bubble_cnt, 16'h1);
      set_fwd(1, 3'd4, 16'h0000, 0, 0, 16'h0);
      #1;
      check("lu_after_stall", 16'(id_stall), 16'(!FWD));
      step();
      if (!FWD) begin
         check("lu_bubble2_valid", 16'(ex_valid), 16'h0);
         check("lu_bubble2_cnt", bubble_cnt, 16'h2);
         set_fwd(0, 0, 16'h0, 1, 3'd4, 16'h00A5);
         #1;
         check("lu_release_stall", 16'(id_stall), 16'h0);
         step();
      end
      set_fwd(0, 0, 16'h0, 1, 3'd4, 16'h00A5);
      #1;
      check("lu_cons_valid", 16'(ex_valid), 16'h1);
      check("lu_cons_inA", ex_inA, 16'h00A5);
      check("lu_cons_inB", ex_inB, 16'h0001);
      check("lu_cons_cnt", bubble_cnt, FWD ? 16'h1 : 16'h2);
      set_fwd(0, 0, 16'h0, 0, 0, 16'h0);

      // EX/MEM vs MEM/WB forward priority on rs (R1)
      set_id(1, 1, 3, 1, 1, 16'h0111, 16'h0003, 16'hFFF0, 0, 4'h4, 3'd6, 0);
      step();
      set_fwd(1, 3'd1, 16'h1234, 1, 3'd1, 16'hBEEF);
      #1;
      check("fwd_exmem_inA", ex_inA, FWD ? 16'h1234 : 16'h0111);
      check("fwd_exmem_inB", ex_inB, 16'h0003);
      set_fwd(0, 3'd1, 16'h1234, 1, 3'd1, 16'hBEEF);
      #1;
      check("fwd_memwb_inA", ex_inA, FWD ? 16'hBEEF : 16'h0111);
      set_fwd(0, 0, 16'h0, 0, 0, 16'h0);
      #1;
      check("fwd_none_inA", ex_inA, 16'h0111);

      // Immediate overrides a forward on rt
      set_id(1, 1, 3, 1, 1, 16'h0111, 16'h0003, 16'hFFF0, 1, 4'h4, 3'd6, 0);
      step();
      set_fwd(1, 3'd3, 16'h5555, 0, 0, 16'h0);
      #1;
      check("imm_inB", ex_inB, 16'hFFF0);
      set_fwd(0, 0, 16'h0, 0, 0, 16'h0);

      // Saturation of the bubble counter
`ifdef ID_EX_FORWARDING_EN
      set_id(1, 1, 0, 1, 0, 16'h0100, 16'h0, 16'h0, 0, 4'h0, 3'd4, 1);
      step();
      force dut.bubble_cnt_q = 16'hFFFF;
      #1;
      release dut.bubble_cnt_q;
      set_id(1, 4, 1, 1, 1, 16'h0000, 16'h0001, 16'h0, 0, 4'h4, 3'd5, 0);
      #1;
      check("sat_stall", 16'(id_stall), 16'h1);
      step();
`else
      set_id(1, 2, 0, 1, 0, 16'h0, 16'h0, 16'h0, 0, 4'h4, 3'd5, 0);
      set_fwd(1, 3'd2, 16'h0, 0, 0, 16'h0);
      #1;
      check("sat_stall", 16'(id_stall), 16'h1);
      repeat (70000) step();
      set_fwd(0, 0, 16'h0, 0, 0, 16'h0);
`endif
      check("sat_valid", 16'(ex_valid), 16'h0);
      check("sat_cnt", bubble_cnt, 16'hFFFF);

      // Asynchronous reset during an external stall
      set_id(1, 1, 2, 1, 1, 16'h0777, 16'h0888, 16'h0, 0, 4'h3, 3'd7, 0);
      #1;
      check("pre_rst_stall", 16'(id_stall), 16'h0);
      step();
      check("pre_rst_valid", 16'(ex_valid), 16'h1);
      ext_stall = 1; flush = 1;
      step();
      check("hold_valid", 16'(ex_valid), 16'h1);
      check("hold_inA", ex_inA, 16'h0777);
      #2;
      rst = 1;
      #1;
      check("async_rst_valid", 16'(ex_valid), 16'h0);
      check("async_rst_cnt", bubble_cnt, 16'h0);
      check("async_rst_inA", ex_inA, 16'h0);
      check("async_rst_stall", 16'(id_stall), 16'h1);
      ext_stall = 0; flush = 0;
      #1;
      check("rst_stall_clear", 16'(id_stall), 16'h0);
      rst = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
